uart_rx_capture: RTL
====================

Name: uart_rx_capture

Overview:
Synthesisable, parametrised UART receive-and-capture block. Deserialises a serial line into characters, checks framing and parity, and buffers good characters in an internal FIFO with a ready/valid drain port. It serves as the on-chip receive path and as a reusable bench-side monitor on the CPU serial_out, so tests can pop captured characters instead of hand-timing bits. It generalises fixed 8N1 capture to configurable data bits, parity, stop bits and buffer depth, and adds error and overflow reporting.

Parameters:
CLOCK_FREQ, 50_000_000, clk frequency in Hz.
BAUD_RATE, 10_000_000, line rate; CPB = CLOCK_FREQ/BAUD_RATE, integer, must be >= 4 (default CPB = 5).
DATA_BITS, 8, character width, 5..9.
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits, 1 or 2.
FIFO_DEPTH, 16, capture buffer entries, power of 2, >= 2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
serial_in  in  1  serial line, idle high, LSB first
enable  in  1  receiver enable; low forces the FSM to IDLE
data_out  out  DATA_BITS  FIFO head character
data_valid  out  1  FIFO non-empty
data_ready  in  1  pop FIFO head when data_valid && data_ready
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
char_count  out  32  total characters pushed since reset, wraps at 2^32
frame_err  out  1  sticky: a stop bit was sampled low
parity_err  out  1  sticky: a parity mismatch occurred
overflow  out  1  sticky: a good character was dropped because the FIFO was full
clear_errs  in  1  synchronous clear of the three sticky flags

Behaviour:
- Reset (rst_n low, asynchronous): FSM = IDLE, synchroniser flops = 1, FIFO empty, data_valid = 0, data_out = 0, fifo_level = 0, char_count = 0, all sticky flags = 0. Reset asserted mid-frame abandons the frame; nothing is pushed.
- serial_in passes through a 2-flop synchroniser before use; all timing below is relative to the synchronised signal (rx_s).
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: when enable = 1 and rx_s = 0, go to START and zero the bit-timer.
- START: at timer = CPB/2 (floor), resample rx_s. If 1, the start bit was a glitch: return to IDLE. If 0, go to DATA with the timer restarted.
- DATA: sample every CPB cycles, at mid-bit; shift in LSB first; after DATA_BITS samples go to PARITY, or to STOP if PARITY = 0.
- PARITY: sample one bit. For even parity, the XOR of data and parity bit must be 0; for odd parity it must be 1.
- STOP: sample STOP_BITS bits; each must be 1.
- Frame end, good frame: push data into the FIFO on the cycle after the last stop sample, increment char_count, return to IDLE.
- Frame end, parity mismatch: set parity_err and drop the character.
- Frame end, stop bit low: set frame_err, drop the character, go to WAIT_IDLE. WAIT_IDLE holds until rx_s = 1 (break handling), then goes to IDLE.
- Latency: data_valid rises 1 cycle after the push cycle.
- enable deasserted mid-frame: return to IDLE next cycle with no push. Sticky flags and FIFO are unaffected.
- FIFO is first-word-fall-through: data_out is valid whenever data_valid = 1.
- Push when full without a same-cycle pop: drop the incoming character, set overflow, keep FIFO contents, do not increment char_count.
- Push and pop in the same cycle when full: both succeed and fifo_level is unchanged.
- Pop when empty: ignored.
- Pointers wrap modulo FIFO_DEPTH.
- clear_errs and a new error event in the same cycle: the error wins and the flag stays 1.

Decomposition:
- Package uart_pkg: rx state enum; parity mode localparams PAR_NONE/PAR_EVEN/PAR_ODD; a function computing CPB with an elaboration-time check that CPB >= 4.
- Sub-module sync_fifo (WIDTH, DEPTH): FWFT, registered level output, simultaneous push/pop support.
- The FSM, timer and shift register stay in uart_rx_capture.

Test Plan:
1. Default 8N1, CPB = 5: send 0x41, data_ready = 0 → data_valid = 1 and data_out = 0x41 exactly 1 cycle after the push; char_count = 1; all error flags = 0.
2. Start-bit glitch: rx low for 2 cycles then high → FSM returns to IDLE, no push. A following 0x5A is captured correctly.
3. Framing error: 0x33 sent with a low stop bit and the line held low 20 cycles, then 0x55 → frame_err = 1, only 0x55 appears in the FIFO, char_count = 1.
4. PARITY = 1: 0x07 with parity bit 1 → captured (XOR = 0). 0x07 with parity bit 0 → parity_err = 1, dropped. Then clear_errs → parity_err = 0.
5. Overflow, FIFO_DEPTH = 16: 17 characters 0x00..0x10 with data_ready = 0 → fifo_level = 16, overflow = 1, char_count = 16. Draining yields 0x00..0x0F in order.
6. Reset mid-frame: pull rst_n low during data bit 3 of 0xA5 → all outputs return to reset values immediately. The next full 0xA5 is captured correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receive-and-capture block:
//   - rx_state_t : receiver FSM state encoding
//   - PAR_*      : parity mode selectors for the PARITY parameter
//   - calc_cpb() : clocks per bit derived from clock and baud frequencies
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Integer clocks per bit. The caller checks the result at elaboration
    // time; anything below 4 leaves no room for a mid-bit sample.
    function automatic int calc_cpb(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   First-word-fall-through synchronous FIFO with registered occupancy.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     push         write push_data this cycle (dropped when full and no pop)
//     push_data    write data
//     pop          consume the head entry (ignored when empty)
//     pop_data     head entry, valid whenever valid = 1 (0 when empty)
//     valid        FIFO non-empty
//     full         FIFO holds DEPTH entries
//     level        current occupancy, 0..DEPTH
//   A push and a pop in the same cycle both take effect, including when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid    = (level != '0);
    assign full     = (level == LW'(DEPTH));
    assign do_pop   = pop && valid;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_capture.sv
// uart_rx_capture
//   UART receiver with framing/parity checking and a FWFT capture buffer.
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     serial_in     serial line, idle high, LSB first
//     enable        receiver enable; low forces the FSM back to idle
//     data_out      head character of the capture FIFO
//     data_valid    capture FIFO non-empty
//     data_ready    drain handshake input
//     fifo_level    current FIFO occupancy
//     char_count    characters accepted into the FIFO since reset (wraps)
//     frame_err     sticky: a stop bit was sampled low
//     parity_err    sticky: a parity mismatch occurred
//     overflow      sticky: a good character was dropped on a full FIFO
//     clear_errs    synchronous clear of the three sticky flags
//   Drain handshake: a character is transferred on every rising clk edge
//   where data_valid && data_ready; data_out is stable while data_valid is
//   high and not yet taken, and data_ready may be asserted at any time.
//   The receiver state is held in the internal signal `state` (rx_state_t).
module uart_rx_capture
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 10_000_000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          serial_in,
    input  logic                          enable,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [31:0]                   char_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overflow,
    input  logic                          clear_errs
);

    localparam int CPB = calc_cpb(CLOCK_FREQ, BAUD_RATE);
    localparam int TW  = $clog2(CPB);

    localparam logic [TW-1:0] HALF_T    = TW'(CPB / 2);
    localparam logic [TW-1:0] LAST_T    = TW'(CPB - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    if (CPB < 4) begin : g_cpb_check
        $error("uart_rx_capture: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end

    rx_state_t            state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [TW-1:0]        timer;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 stop_bad;
    logic                 push_req;
    logic                 frame_evt;
    logic                 parity_evt;
    logic                 fifo_full;
    logic                 pop;
    logic                 accept;
    logic                 drop;

    // Two-flop synchroniser; reset to the idle line level so that leaving
    // reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= serial_in;
            rx_s    <= rx_meta;
        end
    end

    // Receiver FSM. push_req / frame_evt / parity_evt are one-cycle pulses
    // issued on the cycle after the last stop sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            push_req   <= 1'b0;
            frame_evt  <= 1'b0;
            parity_evt <= 1'b0;
        end else begin
            push_req   <= 1'b0;
            frame_evt  <= 1'b0;
            parity_evt <= 1'b0;
            if (!enable) begin
                state <= ST_IDLE;
                timer <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            state <= ST_START;
                            timer <= '0;
                        end
                    end
                    ST_START: begin
                        if (timer == HALF_T) begin
                            // High at mid-start means a glitch, not a frame.
                            state    <= rx_s ? ST_IDLE : ST_DATA;
                            timer    <= '0;
                            bit_cnt  <= '0;
                            par_bad  <= 1'b0;
                            stop_bad <= 1'b0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (timer == LAST_T) begin
                            timer <= '0;
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                            if (bit_cnt == LAST_DATA) begin
                                bit_cnt <= '0;
                                state   <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        if (timer == LAST_T) begin
                            timer   <= '0;
                            // XOR over data and parity bit: 0 for even, 1 for odd.
                            par_bad <= ((^shreg) ^ rx_s) != (PARITY == PAR_ODD);
                            bit_cnt <= '0;
                            state   <= ST_STOP;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (timer == LAST_T) begin
                            timer <= '0;
                            if (bit_cnt == LAST_STOP) begin
                                bit_cnt    <= '0;
                                parity_evt <= par_bad;
                                if (stop_bad || !rx_s) begin
                                    frame_evt <= 1'b1;
                                    state     <= ST_WAIT_IDLE;
                                end else begin
                                    push_req <= !par_bad;
                                    state    <= ST_IDLE;
                                end
                            end else begin
                                bit_cnt  <= bit_cnt + 1'b1;
                                stop_bad <= stop_bad | !rx_s;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        // Hold through a break until the line returns high.
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign pop    = data_valid && data_ready;
    assign accept = push_req && (!fifo_full || pop);
    assign drop   = push_req && fifo_full && !pop;

    // Sticky flags: an event in the same cycle as clear_errs wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overflow   <= 1'b0;
            char_count <= '0;
        end else begin
            if (clear_errs) begin
                frame_err  <= 1'b0;
                parity_err <= 1'b0;
                overflow   <= 1'b0;
            end
            if (frame_evt) begin
                frame_err <= 1'b1;
            end
            if (parity_evt) begin
                parity_err <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (accept) begin
                char_count <= char_count + 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (shreg),
        .pop       (data_ready),
        .pop_data  (data_out),
        .valid     (data_valid),
        .full      (fifo_full),
        .level     (fifo_level)
    );

endmodule
